// File: rtl/insn_prefetch_queue_if.sv
// insn_prefetch_queue_if: byte fetch bus, instruction record bus and flush redirect
interface insn_prefetch_queue_if #(
   parameter int ADDR_N = 16,
   parameter int DATA_N = 8
);
   logic                flush;
   logic [ADDR_N-1:0]   flush_pc;
   logic [ADDR_N-1:0]   fetch_addr;
   logic                byte_valid;
   logic [DATA_N-1:0]   byte_data;
   logic                byte_ready;
   logic                insn_valid;
   logic                insn_ready;
   logic [ADDR_N-1:0]   insn_pc;
   logic [DATA_N-1:0]   insn_op;
   logic [2*DATA_N-1:0] insn_operand;
   logic [3:0]          insn_mode;
   logic [1:0]          insn_len;
   modport master (
      output flush, flush_pc, byte_valid, byte_data, insn_ready,
      input  fetch_addr, byte_ready, insn_valid, insn_pc, insn_op, insn_operand, insn_mode, insn_len
   );
   modport slave (
      input  flush, flush_pc, byte_valid, byte_data, insn_ready,
      output fetch_addr, byte_ready, insn_valid, insn_pc, insn_op, insn_operand, insn_mode, insn_len
   );
endinterface

// File: rtl/insn_prefetch_queue.sv
// insn_prefetch_queue: 6502 byte stream pre-decoder feeding an instruction record FIFO
module insn_prefetch_queue #(
   parameter int ADDR_N = 16,
   parameter int DATA_N = 8,
   parameter int DEPTH  = 4
) (
   input logic clk,
   input logic reset,
   insn_prefetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [3:0] M_IMP = 4'd0, M_IMM = 4'd1, M_IND = 4'd2, M_INDX = 4'd3, M_INDY = 4'd4,
                          M_ZPG = 4'd5, M_ZPGX = 4'd6, M_ZPGY = 4'd7, M_ABS = 4'd8, M_ABSX = 4'd9,
                          M_ABSY = 4'd10, M_RLT = 4'd11;
   typedef enum logic [1:0] {S_OPC, S_LO, S_HI} state_t;
   typedef struct packed {
      logic [ADDR_N-1:0]   pc;
      logic [DATA_N-1:0]   op;
      logic [2*DATA_N-1:0] operand;
      logic [3:0]          mode;
      logic [1:0]          len;
   } rec_t;
   state_t              state_q, state_d;
   logic [ADDR_N-1:0]   fetch_q, fetch_d, pc_q, pc_d;
   logic [DATA_N-1:0]   op_q, op_d, lo_q, lo_d;
   logic [3:0]          mode_q, mode_d, dec_mode;
   logic [1:0]          len_q, len_d, dec_len;
   rec_t                mem_q [DEPTH];
   rec_t                mem_d [DEPTH];
   rec_t                rec, head;
   logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]         count_q, count_d;
   logic                ready, valid, acc, pop, push;
   logic [7:0]          b;
   logic [1:0]          cc;
   logic [2:0]          bbb;
   assign b       = bus.byte_data[7:0];
   assign cc      = b[1:0];
   assign bbb     = b[4:2];
   assign ready   = !reset && !bus.flush && count_q < (PW+1)'(DEPTH);
   assign valid   = !reset && count_q != '0;
   assign acc     = bus.byte_valid && ready;
   assign pop     = valid && bus.insn_ready && !bus.flush;
   assign head    = mem_q[rd_q];
   assign bus.byte_ready   = ready;
   assign bus.fetch_addr   = fetch_q;
   assign bus.insn_valid   = valid;
   assign bus.insn_pc      = valid ? head.pc : '0;
   assign bus.insn_op      = valid ? head.op : '0;
   assign bus.insn_operand = valid ? head.operand : '0;
   assign bus.insn_mode    = valid ? head.mode : '0;
   assign bus.insn_len     = valid ? head.len : '0;
   // classify the incoming byte as an opcode; the irregular opcodes override the column rules
   always_comb begin
      dec_mode = M_IMP;
      dec_len  = 2'd0;
      case (bbb)
         3'd0: begin
            dec_mode = cc[0] ? M_INDX : b[7] ? M_IMM : M_IMP;
            dec_len  = (cc[0] || b[7]) ? 2'd1 : 2'd0;
         end
         3'd1: begin dec_mode = M_ZPG; dec_len = 2'd1; end
         3'd2: begin dec_mode = cc[0] ? M_IMM : M_IMP; dec_len = cc[0] ? 2'd1 : 2'd0; end
         3'd3: begin dec_mode = M_ABS; dec_len = 2'd2; end
         3'd4: begin
            dec_mode = cc == 2'b00 ? M_RLT : cc[0] ? M_INDY : M_IMP;
            dec_len  = cc == 2'b10 ? 2'd0 : 2'd1;
         end
         3'd5: begin dec_mode = (cc[1] && b[7:6] == 2'b10) ? M_ZPGY : M_ZPGX; dec_len = 2'd1; end
         3'd6: begin dec_mode = cc[0] ? M_ABSY : M_IMP; dec_len = cc[0] ? 2'd2 : 2'd0; end
         default: begin dec_mode = (cc[1] && b[7:6] == 2'b10) ? M_ABSY : M_ABSX; dec_len = 2'd2; end
      endcase
      if (b == 8'h00 || b == 8'h40 || b == 8'h60) begin dec_mode = M_IMP; dec_len = 2'd0; end
      if (b == 8'h20) begin dec_mode = M_ABS; dec_len = 2'd2; end
      if (b == 8'h6C) begin dec_mode = M_IND; dec_len = 2'd2; end
   end
   // assemble opcode and operand bytes into a record, pushing it once the last byte arrives
   always_comb begin
      state_d = state_q;
      fetch_d = fetch_q;
      pc_d    = pc_q;
      op_d    = op_q;
      lo_d    = lo_q;
      mode_d  = mode_q;
      len_d   = len_q;
      push    = 1'b0;
      rec     = '0;
      if (acc) begin
         fetch_d = fetch_q + 1'b1;
         case (state_q)
            S_OPC: begin
               pc_d        = fetch_q;
               op_d        = bus.byte_data;
               lo_d        = '0;
               mode_d      = dec_mode;
               len_d       = dec_len;
               push        = dec_len == 2'd0;
               rec.pc      = fetch_q;
               rec.op      = bus.byte_data;
               rec.mode    = dec_mode;
               state_d     = dec_len == 2'd0 ? S_OPC : S_LO;
            end
            S_LO: begin
               lo_d        = bus.byte_data;
               push        = len_q == 2'd1;
               rec.pc      = pc_q;
               rec.op      = op_q;
               rec.operand = {{DATA_N{1'b0}}, bus.byte_data};
               rec.mode    = mode_q;
               rec.len     = len_q;
               state_d     = len_q == 2'd1 ? S_OPC : S_HI;
            end
            default: begin
               push        = 1'b1;
               rec.pc      = pc_q;
               rec.op      = op_q;
               rec.operand = {bus.byte_data, lo_q};
               rec.mode    = mode_q;
               rec.len     = len_q;
               state_d     = S_OPC;
            end
         endcase
      end
      if (bus.flush) begin
         state_d = S_OPC;
         fetch_d = bus.flush_pc;
         pc_d    = '0;
         op_d    = '0;
         lo_d    = '0;
         mode_d  = '0;
         len_d   = '0;
      end
   end
   // record FIFO bookkeeping; a flush empties it regardless of push or pop
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (push) begin
         mem_d[wr_q] = rec;
         wr_d        = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      if (bus.flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_OPC;
         fetch_q <= '0;
         pc_q    <= '0;
         op_q    <= '0;
         lo_q    <= '0;
         mode_q  <= '0;
         len_q   <= '0;
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_q <= fetch_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         lo_q    <= lo_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
endmodule
